// File: rtl/mtr_drv_pkg.sv
// mtr_drv_pkg -- shared types and constants for the three-phase motor gate driver.
//   sel_e      : per-phase drive select encoding
//   drive_t    : raw {high, low} gate request for one phase
//   raw_drive(): maps a select code and the PWM level onto a raw gate request
package mtr_drv_pkg;

  localparam int PWM_W       = 11;   // PWM counter / duty width (2048-clk period)
  localparam int DEAD_T      = 32;   // both-gates-off time after any raw change
  localparam int DT_W        = 5;    // holds DEAD_T-1
  localparam int BLANK_T     = 128;  // ignore over-current this long after a PWM rise
  localparam int BLANK_W     = 8;    // holds BLANK_T
  localparam int OVR_CNT_MAX = 32;   // over-current samples per period that trip shutdown
  localparam int OVR_W       = 6;    // holds OVR_CNT_MAX

  typedef enum logic [1:0] {
    HIGH_Z    = 2'b00,
    REV_CURR  = 2'b01,
    FRWD_CURR = 2'b10,
    BRAKING   = 2'b11
  } sel_e;

  typedef struct packed {
    logic high;
    logic low;
  } drive_t;

  // Braking shorts the winding through the low FET only while PWM is high.
  function automatic drive_t raw_drive(input logic [1:0] sel, input logic pwm);
    drive_t d;
    case (sel_e'(sel))
      HIGH_Z:    begin d.high = 1'b0; d.low = 1'b0; end
      REV_CURR:  begin d.high = ~pwm; d.low = pwm;  end
      FRWD_CURR: begin d.high = pwm;  d.low = ~pwm; end
      BRAKING:   begin d.high = 1'b0; d.low = pwm;  end
      default:   begin d.high = 1'b0; d.low = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mtr_drv_nonoverlap.sv
// nonoverlap -- deadtime insertion for one half-bridge.
//   clk, rst_n          : clock, asynchronous active-low reset
//   high_in, low_in     : raw gate requests
//   force_off           : drive both gates low regardless of the raw request
//   high_out, low_out   : registered gate drives, never both 1
// Any change on the raw pair holds both gates low for DEAD_T clks; a change
// while the hold is running restarts it.
module nonoverlap
  import mtr_drv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic high_in,
  input  logic low_in,
  input  logic force_off,
  output logic high_out,
  output logic low_out
);

  logic [1:0]      raw;
  logic            chg;
  logic [1:0]      raw_prev_q, raw_prev_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic            high_q, high_d;
  logic            low_q, low_d;

  // Detect raw changes, run the deadtime counter and gate the outputs.
  always_comb begin
    raw        = {high_in, low_in};
    chg        = (raw != raw_prev_q);
    raw_prev_d = raw;
    // Loaded with DEAD_T-1: the change cycle itself is the first blocked clk.
    if (chg) begin
      dt_cnt_d = DT_W'(DEAD_T - 1);
    end else if (dt_cnt_q != {DT_W{1'b0}}) begin
      dt_cnt_d = dt_cnt_q - DT_W'(1);
    end else begin
      dt_cnt_d = dt_cnt_q;
    end
    // Both outputs come from one raw sample, and raw never requests both.
    if (force_off || chg || (dt_cnt_q != {DT_W{1'b0}})) begin
      high_d = 1'b0;
      low_d  = 1'b0;
    end else begin
      high_d = raw[1];
      low_d  = raw[0];
    end
  end

  // Deadtime state and registered gate drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_prev_q <= 2'b00;
      dt_cnt_q   <= {DT_W{1'b0}};
      high_q     <= 1'b0;
      low_q      <= 1'b0;
    end else begin
      raw_prev_q <= raw_prev_d;
      dt_cnt_q   <= dt_cnt_d;
      high_q     <= high_d;
      low_q      <= low_d;
    end
  end

  assign high_out = high_q;
  assign low_out  = low_q;

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv -- PWM generator and three-phase FET gate driver with deadtime.
//   clk, rst_n               : 50 MHz clock, asynchronous active-low reset
//   duty[10:0]               : PWM duty, sampled once per period at cnt==0
//   selGrn/selYlw/selBlu     : per-phase drive select (see sel_e)
//   high*/low*               : registered FET gate drives
//   PWM_synch                : one-clk pulse while cnt==0x7FF (period end)
//   ovr_I, ovr_I_shtdwn      : over-current input / latched shutdown status,
//                              present only when OVR_I_SHTDWN_EN is defined
// Optional feature macro: OVR_I_SHTDWN_EN (over-current shutdown).
module mtr_drv
  import mtr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  input  logic [1:0]       selGrn,
  input  logic [1:0]       selYlw,
  input  logic [1:0]       selBlu,
`ifdef OVR_I_SHTDWN_EN
  input  logic             ovr_I,
  output logic             ovr_I_shtdwn,
`endif
  output logic             highGrn,
  output logic             lowGrn,
  output logic             highYlw,
  output logic             lowYlw,
  output logic             highBlu,
  output logic             lowBlu,
  output logic             PWM_synch
);

  localparam logic [PWM_W-1:0] CNT_ZERO    = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0] CNT_LAST_M1 = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d, duty_eff;
  logic             pwm_sig_q, pwm_sig_d;
  logic             pwm_synch_q, pwm_synch_d;
  logic             force_off;
  drive_t           raw_grn, raw_ylw, raw_blu;

  // Counter, per-period duty capture and PWM / synch decode.
  always_comb begin
    cnt_d = cnt_q + PWM_W'(1);
    // The live duty is used in the capture cycle so the new value applies
    // to the whole period that starts there.
    if (cnt_q == CNT_ZERO) begin
      duty_eff = duty;
    end else begin
      duty_eff = duty_q;
    end
    duty_d      = duty_eff;
    pwm_sig_d   = (cnt_q < duty_eff);
    // Decoded one count early so the registered pulse lines up with 0x7FF.
    pwm_synch_d = (cnt_q == CNT_LAST_M1);
  end

  // PWM timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CNT_ZERO;
      duty_q      <= CNT_ZERO;
      pwm_sig_q   <= 1'b0;
      pwm_synch_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      pwm_sig_q   <= pwm_sig_d;
      pwm_synch_q <= pwm_synch_d;
    end
  end

  assign PWM_synch = pwm_synch_q;

`ifdef OVR_I_SHTDWN_EN
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [OVR_W-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic               shtdwn_q, shtdwn_d;

  // Blanking timer after each PWM rise and per-period over-current count.
  always_comb begin
    if (!pwm_sig_q) begin
      blank_d = {BLANK_W{1'b0}};
    end else if (blank_q < BLANK_W'(BLANK_T)) begin
      blank_d = blank_q + BLANK_W'(1);
    end else begin
      blank_d = blank_q;
    end
    if (cnt_q == CNT_ZERO) begin
      ovr_cnt_d = {OVR_W{1'b0}};
    end else if (ovr_I && pwm_sig_q && (blank_q == BLANK_W'(BLANK_T)) &&
                 (ovr_cnt_q < OVR_W'(OVR_CNT_MAX))) begin
      ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
    end else begin
      ovr_cnt_d = ovr_cnt_q;
    end
    // Sticky until rst_n.
    shtdwn_d = shtdwn_q | (ovr_cnt_d == OVR_W'(OVR_CNT_MAX));
  end

  // Over-current protection registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q   <= {BLANK_W{1'b0}};
      ovr_cnt_q <= {OVR_W{1'b0}};
      shtdwn_q  <= 1'b0;
    end else begin
      blank_q   <= blank_d;
      ovr_cnt_q <= ovr_cnt_d;
      shtdwn_q  <= shtdwn_d;
    end
  end

  // Using the next-state value drops the gates in the same clk the flag sets.
  assign force_off    = shtdwn_d;
  assign ovr_I_shtdwn = shtdwn_q;
`else
  assign force_off = 1'b0;
`endif

  assign raw_grn = raw_drive(selGrn, pwm_sig_q);
  assign raw_ylw = raw_drive(selYlw, pwm_sig_q);
  assign raw_blu = raw_drive(selBlu, pwm_sig_q);

  nonoverlap u_no_grn (
    .clk(clk), .rst_n(rst_n), .high_in(raw_grn.high), .low_in(raw_grn.low),
    .force_off(force_off), .high_out(highGrn), .low_out(lowGrn)
  );

  nonoverlap u_no_ylw (
    .clk(clk), .rst_n(rst_n), .high_in(raw_ylw.high), .low_in(raw_ylw.low),
    .force_off(force_off), .high_out(highYlw), .low_out(lowYlw)
  );

  nonoverlap u_no_blu (
    .clk(clk), .rst_n(rst_n), .high_in(raw_blu.high), .low_in(raw_blu.low),
    .force_off(force_off), .high_out(highBlu), .low_out(lowBlu)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv -- scoreboard bench for mtr_drv.
// The stimulus process predicts each cycle's gate drives and PWM_synch from a
// cycle-indexed reference (cnt = cycle mod 2048, per-period duty, and "gate
// follows the previous raw request only if no raw change in the last 32
// cycles") and queues the prediction; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] duty = 11'h000;
  logic [1:0]  selGrn = 2'b00, selYlw = 2'b00, selBlu = 2'b00;
  logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch;
`ifdef OVR_I_SHTDWN_EN
  logic        ovr_I = 1'b0;
  logic        ovr_I_shtdwn;
`endif

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  mtr_drv dut (
    .clk(clk), .rst_n(rst_n), .duty(duty),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
`ifdef OVR_I_SHTDWN_EN
    .ovr_I(ovr_I), .ovr_I_shtdwn(ovr_I_shtdwn),
`endif
    .highGrn(highGrn), .lowGrn(lowGrn), .highYlw(highYlw), .lowYlw(lowYlw),
    .highBlu(highBlu), .lowBlu(lowBlu), .PWM_synch(PWM_synch)
  );

  typedef struct packed {
    int         cyc;
    logic [5:0] gates;   // {hG, lG, hY, lY, hB, lB}
    logic       synch;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (cycle index counted from reset release).
  int         cyc;
  int         m_duty;
  bit         m_pwm;
  int         last_chg[3];
  logic [1:0] raw_prev[3];

  function automatic logic [1:0] raw_of(input logic [1:0] sel, input bit pwm);
    case (sel)
      2'b01:   return {~pwm, pwm};
      2'b10:   return {pwm, ~pwm};
      2'b11:   return {1'b0, pwm};
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_init();
    cyc = 0; m_duty = 0; m_pwm = 1'b0;
    for (int p = 0; p < 3; p++) begin
      last_chg[p] = -1000;
      raw_prev[p] = 2'b00;
    end
    exp_q.delete();
  endtask

  // Called just after a posedge: predicts this cycle, applies inputs, advances.
  task automatic step(input logic [10:0] d, input logic [1:0] sg, input logic [1:0] sy,
                      input logic [1:0] sb);
    exp_t       e;
    logic [1:0] s[3];
    logic [1:0] r;
    e.cyc   = cyc;
    e.synch = ((cyc % 2048) == 2047);
    e.gates = 6'b000000;
    for (int p = 0; p < 3; p++)
      if (last_chg[p] <= cyc - 33) e.gates[5-2*p -: 2] = raw_prev[p];
    exp_q.push_back(e);
    duty = d; selGrn = sg; selYlw = sy; selBlu = sb;
    s[0] = sg; s[1] = sy; s[2] = sb;
    for (int p = 0; p < 3; p++) begin
      r = raw_of(s[p], m_pwm);
      if (r != raw_prev[p]) last_chg[p] = cyc;
      raw_prev[p] = r;
    end
    if ((cyc % 2048) == 0) m_duty = int'(d);
    m_pwm = ((cyc % 2048) < m_duty);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string name);
    logic [6:0] act;
    act = {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch};
    checks++;
    if (act !== 7'b0000000) begin
      errors++;
      $display("FAIL %s got=%b exp=0000000", name, act);
    end
  endtask

  // Scoreboard monitor: one prediction per cycle, compared mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [5:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu};
      checks++;
      if (act !== e.gates) begin
        errors++;
        $display("FAIL gates cyc=%0d got=%b exp=%b", e.cyc, act, e.gates);
      end
      checks++;
      if (PWM_synch !== e.synch) begin
        errors++;
        $display("FAIL pwm_synch cyc=%0d got=%b exp=%b", e.cyc, PWM_synch, e.synch);
      end
      checks++;
      if ((highGrn & lowGrn) | (highYlw & lowYlw) | (highBlu & lowBlu)) begin
        errors++;
        $display("FAIL overlap cyc=%0d got=%b exp=no_pair_high", e.cyc, act);
      end
    end
  end

  logic [1:0]  rg, ry, rb;
  logic [10:0] rd;
  int          hg, lg;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst_n = 1'b1;
    model_init();

    // Green forward at 50 % duty; count a full aligned period of gate time.
    hg = 0; lg = 0;
    while (cyc < 4200) begin
      if (cyc >= 2050 && cyc <= 4097) begin
        hg += int'(highGrn);
        lg += int'(lowGrn);
      end
      step(11'h400, 2'b10, 2'b00, 2'b00);
    end
    checks++;
    if (hg != 992) begin errors++; $display("FAIL high_grn_time got=%0d exp=992", hg); end
    checks++;
    if (lg != 992) begin errors++; $display("FAIL low_grn_time got=%0d exp=992", lg); end

    // All phases braking at 0x600.
    while (cyc < 8300) step(11'h600, 2'b11, 2'b11, 2'b11);
    // Green forward, then reversed in the middle of the high phase.
    while (cyc < 8500) step(11'h400, 2'b10, 2'b00, 2'b00);
    while (cyc < 10240) step(11'h400, 2'b01, 2'b00, 2'b00);

    // Random selects and duty; captured duty forced to 0 and 0x7FF in two periods.
    rg = 2'b01; ry = 2'b10; rb = 2'b11;
    while (cyc < 10240 + 4 * 2048 + 928) begin
      if ($urandom_range(0, 255) == 0) begin
        case ($urandom_range(0, 2))
          0:       rg = 2'($urandom_range(0, 3));
          1:       ry = 2'($urandom_range(0, 3));
          default: rb = 2'($urandom_range(0, 3));
        endcase
      end
      rd = 11'($urandom);
      if ((cyc % 2048) == 0) begin
        case ((cyc / 2048) % 4)
          1:       rd = 11'h000;
          2:       rd = 11'h7FF;
          default: rd = 11'($urandom);
        endcase
      end
      step(rd, rg, ry, rb);
    end

    // Asynchronous reset at cnt == 0x3A0: outputs clear without a clock edge.
    checks++;
    if ((cyc % 2048) != 11'h3A0) begin
      errors++;
      $display("FAIL reset_align got=%0d exp=%0d", cyc % 2048, 11'h3A0);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    repeat (4) @(posedge clk);
    #1;
    chk_zero("held_reset");
    rst_n = 1'b1;
    model_init();
    while (cyc < 2100) step(11'($urandom), 2'b10, 2'b01, 2'b11);
    @(negedge clk); #1;

`ifdef OVR_I_SHTDWN_EN
    rst_n = 1'b0; ovr_I = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; duty = 11'h7FF; selGrn = 2'b10; selYlw = 2'b00; selBlu = 2'b00;
    for (int c = 0; c < 2200; c++) begin
      ovr_I = ((c >= 10 && c <= 100) || (c >= 300 && c < 340));
      if (c == 200) begin
        checks++;
        if (ovr_I_shtdwn !== 1'b0) begin
          errors++; $display("FAIL ovr_blanked got=%b exp=0", ovr_I_shtdwn);
        end
      end
      if (c == 299) begin
        checks++;
        if (highGrn !== 1'b1) begin
          errors++; $display("FAIL ovr_pre_drive got=%b exp=1", highGrn);
        end
      end
      if (c == 345 || c == 2199) begin
        checks++;
        if ({ovr_I_shtdwn, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu} !== 7'b1000000) begin
          errors++;
          $display("FAIL ovr_shutdown c=%0d got=%b exp=1000000", c,
                   {ovr_I_shtdwn, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu});
        end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0; ovr_I = 1'b0;
    #1;
    checks++;
    if (ovr_I_shtdwn !== 1'b0) begin
      errors++; $display("FAIL ovr_reset got=%b exp=0", ovr_I_shtdwn);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
